sgf_mult_sequencer: RTL and testbench
=====================================

Name: sgf_mult_sequencer

Overview:
- Sequences the shared Karatsuba significand multiplier (Sgf_Multiplication) between two requesters, e.g. the FPU mul path and the div/sqrt iteration path.
- Registers the granted operands and holds them on the multiplier inputs for the multiplier's internal pipeline depth.
- Pulses the multiplier's final-register load (load_b_i) exactly once, then presents the product with a valid/ready handshake and requester tag.
- Sits between the FPU operation control and the multiplier instance.

Parameters:
- SW, 24, significand width; operand width SW, product width 2*SW (24 single, 54 double).
- MULT_LAT, 2, clock cycles from operands stable on the multiplier inputs until its final-register D input is valid; 0 allowed; must match the instantiated multiplier.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- req0_valid_i  in  1  requester 0 has operands
- req0_ready_o  out  1  requester 0 accepted this cycle
- req0_a_i  in  SW  requester 0 operand A
- req0_b_i  in  SW  requester 0 operand B
- req1_valid_i  in  1  requester 1 has operands
- req1_ready_o  out  1  requester 1 accepted this cycle
- req1_a_i  in  SW  requester 1 operand A
- req1_b_i  in  SW  requester 1 operand B
- mul_a_o  out  SW  to multiplier Data_A_i
- mul_b_o  out  SW  to multiplier Data_B_i
- mul_load_b_o  out  1  to multiplier load_b_i
- mul_result_i  in  2*SW  from multiplier sgf_result_o
- res_valid_o  out  1  product valid
- res_ready_i  in  1  consumer accepts product
- res_data_o  out  2*SW  product; equals mul_result_i
- res_id_o  out  1  requester that owns the product (0/1)
- busy_o  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, every output register 0, res_valid_o=0, mul_load_b_o=0, mul_a_o=mul_b_o=0, res_id_o=0, round-robin pointer=1 (so req0 wins first tie), latency counter=0.
- States: IDLE, WAIT, LOAD, DONE.
- IDLE:
  - Grant selection: only req0 valid -> grant 0; only req1 valid -> grant 1; both valid -> grant the requester not equal to the pointer.
  - reqN_ready_o=1 combinationally only for the granted requester, and only in IDLE.
  - On the handshake edge: latch a/b into mul_a_o/mul_b_o, latch id into res_id_o, pointer<=grant, counter<=MULT_LAT.
  - Next state: WAIT if MULT_LAT>0, else LOAD.
- WAIT: counter decrements each cycle; moves to LOAD on the edge where the counter reaches 1.
- LOAD: mul_load_b_o=1 for exactly this one cycle (registered output). The multiplier's final register captures at the end of the cycle. Next state DONE.
- DONE:
  - res_valid_o=1; res_data_o=mul_result_i, stable because load is low.
  - Hold until res_ready_i=1, then go to IDLE.
  - No new grant in the same cycle.
- Timing:
  - Handshake at edge E0 -> mul_load_b_o high during the cycle after edge E0+MULT_LAT.
  - res_valid_o first high after edge E0+MULT_LAT+1.
  - Minimum issue spacing is MULT_LAT+3 cycles.
- mul_a_o, mul_b_o and res_id_o are unchanged from E0 until the next grant.
- A requester that drops valid before it is granted is not recorded. Requesters must hold their operands until ready.
- res_ready_i is ignored outside DONE.
- rst in any state (including LOAD) returns to reset values in the next cycle. The aborted product is discarded and no res_valid_o is issued.
- mul_load_b_o is never high outside LOAD.

Optional Feature:
- Macro: SGF_SEQ_PERF_EN.
- With the macro defined, two extra output ports exist:
  - op_count_o (32 bits): increments on every res handshake.
  - stall_count_o (32 bits): increments each cycle in DONE with res_ready_i=0.
  - Both counters wrap at 2^32 and clear on rst.
- Without the macro, neither port nor the counter logic exists; all other behaviour is identical.

Test Plan:
- Reset, then req0 A=0x800000 B=0x800000 (SW=24, MULT_LAT=2) -> req0_ready_o high 1 cycle; mul_load_b_o high in 3rd cycle after E0; res_valid_o=1 with res_data_o=0x400000000000 and res_id_o=0.
- req0 and req1 valid together from reset, consumer always ready -> grants alternate 0,1,0,1; each product correct (req1 A=0xFFFFFF B=0xFFFFFF -> 0xFFFFFE000001).
- Hold res_ready_i=0 for 5 cycles in DONE -> res_valid_o and res_data_o stable; mul_load_b_o stays 0; with SGF_SEQ_PERF_EN, stall_count_o=5 and op_count_o=1 after accept.
- Assert rst during LOAD -> next cycle busy_o=0, res_valid_o=0, mul_load_b_o=0; no result is delivered; next req0 is granted first.
- MULT_LAT=0, A=3 B=5 -> mul_load_b_o in the cycle after E0; res_data_o=15 one cycle later.
- req1 asserts valid while the block is in WAIT -> req1_ready_o stays 0 until IDLE; req1 is then granted with its held operands.

Source files
------------

// File: rtl/sgf_mult_sequencer.sv
// -----------------------------------------------------------------------------
// sgf_mult_sequencer
//
// Shares one Karatsuba significand multiplier (Sgf_Multiplication) between two
// requesters, for example the FPU mul path and the div/sqrt iteration path.
// The sequencer grants one requester and registers its operands onto the
// multiplier inputs. It holds them there for the multiplier's pipeline depth
// (MULT_LAT), then pulses the multiplier's final-register load exactly once.
// The product is offered to the consumer with a valid/ready handshake and a
// tag that names the owning requester.
//
// Parameters:
//   SW        significand width; operands are SW bits, the product is 2*SW bits
//   MULT_LAT  cycles from stable operands on the multiplier inputs until the
//             multiplier's final-register D input is valid (0 allowed). It
//             must match the instantiated multiplier.
//
// Ports:
//   clk, rst               clock (rising edge); synchronous active-high reset
//   req0_valid_i/ready_o   requester 0 handshake; ready is high only in IDLE,
//                          and only for the granted requester
//   req0_a_i, req0_b_i     requester 0 operands (held until ready)
//   req1_*                 same set for requester 1
//   mul_a_o, mul_b_o       registered operands to multiplier Data_A_i/Data_B_i
//   mul_load_b_o           one-cycle pulse to the multiplier load_b_i
//   mul_result_i           multiplier sgf_result_o
//   res_valid_o/ready_i    product handshake toward the consumer
//   res_data_o             product (a copy of mul_result_i)
//   res_id_o               requester that owns the product
//   busy_o                 high whenever the sequencer is not idle
//
// Optional feature (macro SGF_SEQ_PERF_EN):
//   op_count_o             32-bit count of product handshakes (wraps)
//   stall_count_o          32-bit count of DONE cycles with res_ready_i low
// -----------------------------------------------------------------------------
module sgf_mult_sequencer #(
    parameter int SW       = 24,
    parameter int MULT_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic [SW-1:0]     req0_a_i,
    input  logic [SW-1:0]     req0_b_i,

    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic [SW-1:0]     req1_a_i,
    input  logic [SW-1:0]     req1_b_i,

    output logic [SW-1:0]     mul_a_o,
    output logic [SW-1:0]     mul_b_o,
    output logic              mul_load_b_o,
    input  logic [2*SW-1:0]   mul_result_i,

    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [2*SW-1:0]   res_data_o,
    output logic              res_id_o,

    output logic              busy_o
`ifdef SGF_SEQ_PERF_EN
    ,
    output logic [31:0]       op_count_o,
    output logic [31:0]       stall_count_o
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        LOAD,
        DONE
    } state_t;

    // The counter must hold MULT_LAT. It is at least one bit wide, so that
    // MULT_LAT = 0 still elaborates.
    localparam int CW = (MULT_LAT < 2) ? 1 : $clog2(MULT_LAT + 1);

    state_t          state;
    state_t          state_next;
    logic            ptr;        // requester served last; the other one wins a tie
    logic [CW-1:0]   cnt;        // pipeline cycles still to wait in WAIT
    logic            any_req;
    logic            grant;      // 0 = requester 0, 1 = requester 1
    logic            accept;     // handshake with the granted requester this cycle
    logic            res_fire;   // product handshake this cycle

    // -------------------------------------------------------------------------
    // Grant selection. This logic is meaningful only in IDLE. A requester that
    // drops valid before it is granted simply never shows up here.
    // -------------------------------------------------------------------------
    always_comb begin
        any_req = req0_valid_i | req1_valid_i;
        if (req0_valid_i && req1_valid_i) begin
            grant = ~ptr;
        end else begin
            grant = req1_valid_i;
        end
        accept   = (state == IDLE) && any_req;
        res_fire = (state == DONE) && res_ready_i;
    end

    assign req0_ready_o = accept & ~grant;
    assign req1_ready_o = accept &  grant;
    assign busy_o       = (state != IDLE);

    // The multiplier's final register holds its value while load_b_i is low,
    // so the product can be passed straight through for the whole DONE phase.
    assign res_data_o   = mul_result_i;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: the default is assigned before the case, so every path writes
        // state_next and no latch is inferred.
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (MULT_LAT > 0) ? WAIT : LOAD;
                end
            end
            WAIT: begin
                // cnt was loaded with MULT_LAT at the grant. It reads 1 on the
                // last waiting cycle, so the multiplier's D input becomes valid
                // at the edge that enters LOAD.
                if (cnt <= CW'(1)) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                state_next = DONE;
            end
            DONE: begin
                if (res_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State, operand and handshake registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge, whatever order the
    // statements appear in.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= 1'b1;     // requester 0 wins the first tie
            cnt          <= '0;
            mul_a_o      <= '0;
            mul_b_o      <= '0;
            res_id_o     <= 1'b0;
            mul_load_b_o <= 1'b0;
            res_valid_o  <= 1'b0;
        end else begin
            state        <= state_next;
            // Registered from the next state, so the load pulse lines up
            // exactly with the single LOAD cycle and is never high elsewhere.
            mul_load_b_o <= (state_next == LOAD);
            res_valid_o  <= (state_next == DONE);

            unique case (state)
                IDLE: begin
                    if (accept) begin
                        // Operands and tag stay unchanged until the next grant.
                        mul_a_o  <= grant ? req1_a_i : req0_a_i;
                        mul_b_o  <= grant ? req1_b_i : req0_b_i;
                        res_id_o <= grant;
                        ptr      <= grant;
                        cnt      <= CW'(MULT_LAT);
                    end
                end
                WAIT: begin
                    cnt <= cnt - CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SGF_SEQ_PERF_EN
    // -------------------------------------------------------------------------
    // Performance counters. Both wrap naturally at 2^32.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            op_count_o    <= '0;
            stall_count_o <= '0;
        end else begin
            if (res_fire) begin
                op_count_o <= op_count_o + 32'd1;
            end
            if ((state == DONE) && !res_ready_i) begin
                stall_count_o <= stall_count_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sgf_mult_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sgf_mult_sequencer
//
// Bench for sgf_mult_sequencer. Two instances are built: the default
// configuration (SW=24, MULT_LAT=2) and a zero-latency one (MULT_LAT=0).
// Each instance drives a small behavioural multiplier: a delay line of depth
// MULT_LAT on the product, followed by a final register loaded by load_b.
// A transaction-level reference model predicts the following from the
// requester valids and the grant timestamps:
//   - which requester is granted
//   - when the load pulse and the product appear
//   - which product and tag must be delivered
// -----------------------------------------------------------------------------
module tb_sgf_mult_sequencer;

    localparam int SW  = 24;
    localparam int PW  = 2 * SW;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- main instance (MULT_LAT = 2) ----------------
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic [SW-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic          req0_ready, req1_ready;
    logic [SW-1:0] mul_a, mul_b;
    logic          mul_load_b;
    logic [PW-1:0] mul_result = '0;
    logic          res_valid;
    logic          res_ready = 1'b1;
    logic [PW-1:0] res_data;
    logic          res_id;
    logic          busy;
`ifdef SGF_SEQ_PERF_EN
    logic [31:0]   op_count, stall_count;
`endif

    sgf_mult_sequencer #(.SW(SW), .MULT_LAT(LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid_i (req0_valid),
        .req0_ready_o (req0_ready),
        .req0_a_i     (req0_a),
        .req0_b_i     (req0_b),
        .req1_valid_i (req1_valid),
        .req1_ready_o (req1_ready),
        .req1_a_i     (req1_a),
        .req1_b_i     (req1_b),
        .mul_a_o      (mul_a),
        .mul_b_o      (mul_b),
        .mul_load_b_o (mul_load_b),
        .mul_result_i (mul_result),
        .res_valid_o  (res_valid),
        .res_ready_i  (res_ready),
        .res_data_o   (res_data),
        .res_id_o     (res_id),
        .busy_o       (busy)
`ifdef SGF_SEQ_PERF_EN
        ,
        .op_count_o   (op_count),
        .stall_count_o(stall_count)
`endif
    );

    // Multiplier model: two pipeline stages, then the final register.
    logic [PW-1:0] pipe1 = '0, pipe2 = '0;
    always @(posedge clk) begin
        pipe1 <= PW'(mul_a) * PW'(mul_b);
        pipe2 <= pipe1;
        if (mul_load_b) mul_result <= pipe2;
    end

    // ---------------- zero-latency instance ----------------
    logic          z_req0_valid = 1'b0;
    logic [SW-1:0] z_req0_a = '0, z_req0_b = '0;
    logic          z_req0_ready, z_req1_ready;
    logic [SW-1:0] z_mul_a, z_mul_b;
    logic          z_mul_load_b;
    logic [PW-1:0] z_mul_result = '0;
    logic          z_res_valid;
    logic [PW-1:0] z_res_data;
    logic          z_res_id, z_busy;
`ifdef SGF_SEQ_PERF_EN
    logic [31:0]   z_op_count, z_stall_count;
`endif

    sgf_mult_sequencer #(.SW(SW), .MULT_LAT(0)) dut_z (
        .clk          (clk),
        .rst          (rst),
        .req0_valid_i (z_req0_valid),
        .req0_ready_o (z_req0_ready),
        .req0_a_i     (z_req0_a),
        .req0_b_i     (z_req0_b),
        .req1_valid_i (1'b0),
        .req1_ready_o (z_req1_ready),
        .req1_a_i     ('0),
        .req1_b_i     ('0),
        .mul_a_o      (z_mul_a),
        .mul_b_o      (z_mul_b),
        .mul_load_b_o (z_mul_load_b),
        .mul_result_i (z_mul_result),
        .res_valid_o  (z_res_valid),
        .res_ready_i  (1'b1),
        .res_data_o   (z_res_data),
        .res_id_o     (z_res_id),
        .busy_o       (z_busy)
`ifdef SGF_SEQ_PERF_EN
        ,
        .op_count_o   (z_op_count),
        .stall_count_o(z_stall_count)
`endif
    );

    always @(posedge clk) begin
        if (z_mul_load_b) z_mul_result <= PW'(z_mul_a) * PW'(z_mul_b);
    end

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model (main instance) ----------------
    typedef struct {
        logic          id;
        logic [SW-1:0] a;
        logic [SW-1:0] b;
    } txn_t;

    txn_t        m_q[$];
    logic        m_idle   = 1'b1;   // no transaction in flight
    logic        m_ptr    = 1'b1;   // last served requester
    int          m_gcyc   = 0;      // cycle in which the in-flight grant happened
    int unsigned m_ops    = 0;
    int unsigned m_stalls = 0;
    logic        exp_r0, exp_r1, exp_done;
    txn_t        t_cur;

    always @(negedge clk) begin
        if (rst) begin
            m_idle   = 1'b1;
            m_ptr    = 1'b1;
            m_ops    = 0;
            m_stalls = 0;
            m_q.delete();
        end else begin
            exp_r0   = m_idle && req0_valid && (!req1_valid || m_ptr);
            exp_r1   = m_idle && req1_valid && (!req0_valid || !m_ptr);
            exp_done = !m_idle && (cyc >= m_gcyc + LAT + 2);
            check("ready0", req0_ready, exp_r0);
            check("ready1", req1_ready, exp_r1);
            check("busy", busy, !m_idle && (cyc > m_gcyc));
            check("load_b", mul_load_b, !m_idle && (cyc == m_gcyc + LAT + 1));
            check("res_valid", res_valid, exp_done);
`ifdef SGF_SEQ_PERF_EN
            check("op_count", op_count, m_ops);
            check("stall_count", stall_count, m_stalls);
`endif
            if (exp_done && res_ready) begin
                if (m_q.size() == 0) begin
                    check("orphan_result", 1'b1, 1'b0);
                end else begin
                    t_cur = m_q.pop_front();
                    check("res_data", res_data, PW'(t_cur.a) * PW'(t_cur.b));
                    check("res_id", res_id, t_cur.id);
                    check("mul_a_hold", mul_a, t_cur.a);
                    check("mul_b_hold", mul_b, t_cur.b);
                end
                m_ops++;
                m_idle = 1'b1;
            end else if (exp_done) begin
                m_stalls++;
            end
            if (exp_r0 || exp_r1) begin
                t_cur.id = exp_r1;
                t_cur.a  = exp_r1 ? req1_a : req0_a;
                t_cur.b  = exp_r1 ? req1_b : req0_b;
                m_q.push_back(t_cur);
                m_ptr  = exp_r1;
                m_gcyc = cyc;
                m_idle = 1'b0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [SW-1:0] rand_op();
        int unsigned sel;
        sel = $urandom_range(0, 7);
        if (sel == 0) return '0;
        if (sel == 1) return '1;
        return SW'($urandom);
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic wait_ready(input logic which, input string tag, output int hs);
        hs = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (which ? req1_ready : req0_ready) begin
                hs = cyc;
                break;
            end
        end
        check({tag, "_granted"}, hs >= 0, 1'b1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 60);
        check({tag, "_idle"}, busy, 1'b0);
    endtask

    // ---------------- main sequence ----------------
    int            hs;
    int            g1;
    int            nres;
    logic          grants[$];
    logic [PW-1:0] held;
    logic [SW-1:0] ta, tb2;
    logic          acc0, acc1;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_load_b", mul_load_b, 1'b0);
        check("rst_mul_a", mul_a, '0);
        check("rst_res_id", res_id, 1'b0);

        // Single req0 transaction: 0x800000 * 0x800000
        @(posedge clk); #1;
        req0_a = 24'h800000; req0_b = 24'h800000; req0_valid = 1'b1;
        @(negedge clk);
        check("t1_ready0", req0_ready, 1'b1);
        @(posedge clk); #1 req0_valid = 1'b0;
        @(negedge clk);
        check("t1_ready0_once", req0_ready, 1'b0);
        check("t1_load_c1", mul_load_b, 1'b0);
        @(negedge clk);
        check("t1_load_c2", mul_load_b, 1'b0);
        @(negedge clk);
        check("t1_load_c3", mul_load_b, 1'b1);
        check("t1_valid_c3", res_valid, 1'b0);
        @(negedge clk);
        check("t1_valid_c4", res_valid, 1'b1);
        check("t1_data", res_data, 48'h400000000000);
        check("t1_id", res_id, 1'b0);
        check("t1_load_c4", mul_load_b, 1'b0);
        @(negedge clk);
        check("t1_busy_after", busy, 1'b0);
`ifdef SGF_SEQ_PERF_EN
        check("t1_op_count", op_count, 32'd1);
`endif

        // Both requesters valid from reset: grants alternate 0,1,0,1
        do_reset();
        req0_a = 24'h800000; req0_b = 24'h800000;
        req1_a = 24'hFFFFFF; req1_b = 24'hFFFFFF;
        req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
        nres = 0;
        grants.delete();
        for (int c = 0; c < 80 && nres < 4; c++) begin
            @(negedge clk);
            if (req0_ready) grants.push_back(1'b0);
            if (req1_ready) grants.push_back(1'b1);
            if (res_valid && res_ready) begin
                check("t2_id", res_id, nres % 2);
                check("t2_data", res_data, (nres % 2) ? 48'hFFFFFE000001 : 48'h400000000000);
                nres++;
            end
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("t2_results", nres, 4);
        check("t2_grants", grants.size(), 4);
        for (int i = 0; i < grants.size() && i < 4; i++) begin
            check("t2_grant_order", grants[i], i % 2);
        end

        // Consumer stalls for 5 DONE cycles
        do_reset();
        res_ready = 1'b0;
        ta = rand_op(); tb2 = rand_op();
        req0_a = ta; req0_b = tb2; req0_valid = 1'b1;
        wait_ready(1'b0, "t3", hs);
        @(posedge clk); #1 req0_valid = 1'b0;
        for (int c = 0; c < 20 && !res_valid; c++) @(negedge clk);
        check("t3_valid_seen", res_valid, 1'b1);
        held = res_data;
        check("t3_data", held, PW'(ta) * PW'(tb2));
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("t3_valid_stable", res_valid, 1'b1);
            check("t3_data_stable", res_data, held);
            check("t3_load_low", mul_load_b, 1'b0);
        end
        @(posedge clk); #1 res_ready = 1'b1;
        @(negedge clk);
        check("t3_accept_valid", res_valid, 1'b1);
        @(negedge clk);
        check("t3_valid_gone", res_valid, 1'b0);
`ifdef SGF_SEQ_PERF_EN
        check("t3_stall_count", stall_count, 32'd5);
        check("t3_op_count", op_count, 32'd1);
`endif

        // Reset during LOAD discards the product and resets the round-robin
        @(posedge clk); #1;
        req0_a = rand_op(); req0_b = rand_op(); req0_valid = 1'b1;
        wait_ready(1'b0, "t4", hs);
        repeat (LAT + 1) @(posedge clk);
        #1;
        req0_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("t4_in_load", mul_load_b, 1'b1);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("t4_busy", busy, 1'b0);
        check("t4_res_valid", res_valid, 1'b0);
        check("t4_load_b", mul_load_b, 1'b0);
        check("t4_mul_a", mul_a, '0);
        check("t4_mul_b", mul_b, '0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("t4_no_result", res_valid, 1'b0);
        end
        @(posedge clk); #1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        check("t4_first_tie_r0", req0_ready, 1'b1);
        check("t4_first_tie_r1", req1_ready, 1'b0);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_idle("t4");

        // req1 arrives while the block is in WAIT
        @(posedge clk); #1;
        req0_a = rand_op(); req0_b = rand_op(); req0_valid = 1'b1;
        wait_ready(1'b0, "t6", hs);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        ta = rand_op(); tb2 = rand_op();
        req1_a = ta; req1_b = tb2; req1_valid = 1'b1;
        g1 = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (req1_ready) begin
                g1 = cyc;
                break;
            end
        end
        check("t6_grant_delay", g1 - hs, LAT + 3);
        @(posedge clk); #1 req1_valid = 1'b0;
        @(negedge clk);
        check("t6_mul_a", mul_a, ta);
        check("t6_mul_b", mul_b, tb2);
        check("t6_res_id", res_id, 1'b1);
        wait_idle("t6");

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
            @(posedge clk); #1;
            if (req0_valid && !acc0 && $urandom_range(0, 15) == 0) begin
                req0_valid = 1'b0;
            end else if (!req0_valid || acc0) begin
                req0_valid = 1'($urandom_range(0, 1));
                req0_a = rand_op(); req0_b = rand_op();
            end
            if (req1_valid && !acc1 && $urandom_range(0, 15) == 0) begin
                req1_valid = 1'b0;
            end else if (!req1_valid || acc1) begin
                req1_valid = 1'($urandom_range(0, 1));
                req1_a = rand_op(); req1_b = rand_op();
            end
            res_ready = ($urandom_range(0, 3) != 0);
        end
        req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
        wait_idle("rand");
        @(negedge clk);
        check("rand_drained", m_q.size(), 0);

        // Zero-latency instance: 3 * 5
        @(posedge clk); #1;
        z_req0_a = 24'd3; z_req0_b = 24'd5; z_req0_valid = 1'b1;
        @(negedge clk);
        check("z_ready0", z_req0_ready, 1'b1);
        check("z_load_e0", z_mul_load_b, 1'b0);
        @(posedge clk); #1 z_req0_valid = 1'b0;
        @(negedge clk);
        check("z_load_c1", z_mul_load_b, 1'b1);
        check("z_valid_c1", z_res_valid, 1'b0);
        @(negedge clk);
        check("z_valid_c2", z_res_valid, 1'b1);
        check("z_data", z_res_data, 48'd15);
        check("z_id", z_res_id, 1'b0);
        check("z_load_c2", z_mul_load_b, 1'b0);
        @(negedge clk);
        check("z_busy_after", z_busy, 1'b0);
        check("z_ready1_never", z_req1_ready, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
